// File: rtl/gpio_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_timer_pkg
// Description : Register indices, CTRL bit positions and default region tag
//               for the memory-mapped GPIO/timer peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_timer_pkg;

    localparam logic [2:0] REG_COUNT    = 3'd0;
    localparam logic [2:0] REG_LOAD     = 3'd1;
    localparam logic [2:0] REG_CTRL     = 3'd2;
    localparam logic [2:0] REG_GPIO_OUT = 3'd3;
    localparam logic [2:0] REG_GPIO_IN  = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_AR  = 1;
    localparam int CTRL_IRQ = 2;

    localparam logic [7:0] DEFAULT_REGION_TAG = 8'h05;

endpackage
`default_nettype wire

// File: rtl/gpio_timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_timer_counter
// Description : Prescaler plus 32-bit down-counter with one-shot / auto-reload.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_timer_counter
    import gpio_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic        i_auto_reload,
    input  logic [31:0] i_load,
    input  logic        i_start,
    output logic [31:0] o_count,
    output logic        o_expire,
    output logic        o_stop
);

    localparam int              c_pw          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pw-1:0] c_presc_last  = c_pw'(PRESCALE - 1);

    logic [c_pw-1:0] r_presc;
    logic [31:0]     r_count;
    logic            r_reload_pend;
    logic            w_tick;

    // A pending reload consumes the tick after an auto-reload expiry.
    assign w_tick   = i_enable && !i_start && (r_presc == c_presc_last);
    assign o_expire = w_tick && !r_reload_pend && (r_count <= 32'd1);
    assign o_stop   = o_expire && !i_auto_reload;
    assign o_count  = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_count       <= '0;
            r_reload_pend <= 1'b0;
        end else if (i_start) begin
            r_presc       <= '0;
            r_count       <= i_load;
            r_reload_pend <= 1'b0;
        end else if (i_enable) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                if (r_reload_pend) begin
                    r_count       <= i_load;
                    r_reload_pend <= 1'b0;
                end else if (r_count == 32'd1) begin
                    r_count       <= '0;
                    r_reload_pend <= i_auto_reload;
                end else if (r_count == 32'd0) begin
                    r_count <= i_auto_reload ? i_load : 32'd0;
                end else begin
                    r_count <= r_count - 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpio_timer_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : gpio_timer_peripheral
// Description : Memory-mapped GPIO and timer responder with registered reads.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_timer_peripheral
    import gpio_timer_pkg::*;
#(
    parameter int         GPIO_WIDTH = 16,
    parameter logic [7:0] REGION_TAG = DEFAULT_REGION_TAG,
    parameter int         PRESCALE   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [63:0]           address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [63:0]           write_data,
    output logic [63:0]           read_data,
    output logic                  read_valid,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  timer_irq
);

    logic                  w_sel, w_rd, w_wr, w_ctrl_wr;
    logic [2:0]            w_idx;
    logic                  w_en_eff, w_start, w_expire, w_stop;
    logic [31:0]           w_count;
    logic [63:0]           w_rdata;
    logic                  w_unused;

    logic [GPIO_WIDTH-1:0] r_sync1, r_sync2, r_gpio_out;
    logic [31:0]           r_load;
    logic [2:0]            r_ctrl;
    logic                  r_status;
    logic [63:0]           r_read_data;
    logic                  r_read_valid;

    assign w_sel     = (address[63:56] == REGION_TAG);
    assign w_idx     = address[2:0];
    assign w_rd      = mem_read && w_sel;
    assign w_wr      = mem_write && w_sel;
    assign w_ctrl_wr = w_wr && (w_idx == REG_CTRL);
    assign w_unused  = &{1'b0, address[55:3], write_data[63:32]};

    // A CTRL write is seen by the counter on its own edge so a disable beats a tick.
    assign w_en_eff = w_ctrl_wr ? write_data[CTRL_EN] : r_ctrl[CTRL_EN];
    assign w_start  = w_ctrl_wr && write_data[CTRL_EN] && !r_ctrl[CTRL_EN];

    gpio_timer_counter #(
        .PRESCALE (PRESCALE)
    ) u_counter (
        .clk           (clock),
        .rst_n         (reset_n),
        .i_enable      (w_en_eff),
        .i_auto_reload (r_ctrl[CTRL_AR]),
        .i_load        (r_load),
        .i_start       (w_start),
        .o_count       (w_count),
        .o_expire      (w_expire),
        .o_stop        (w_stop)
    );

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_COUNT:    w_rdata = {32'd0, w_count};
            REG_LOAD:     w_rdata = {32'd0, r_load};
            REG_CTRL:     w_rdata = {61'd0, r_ctrl};
            REG_GPIO_OUT: w_rdata = 64'(r_gpio_out);
            REG_GPIO_IN:  w_rdata = 64'(r_sync2);
            REG_STATUS:   w_rdata = {63'd0, r_status};
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_gpio_out   <= '0;
            r_load       <= '0;
            r_ctrl       <= '0;
            r_status     <= 1'b0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_sync1      <= gpio_in;
            r_sync2      <= r_sync1;
            r_read_valid <= w_rd;
            if (w_rd)
                r_read_data <= w_rdata;
            if (w_wr && (w_idx == REG_LOAD))
                r_load <= write_data[31:0];
            if (w_ctrl_wr)
                r_ctrl <= write_data[2:0];
            else if (w_stop)
                r_ctrl[CTRL_EN] <= 1'b0;
            if (w_wr && (w_idx == REG_GPIO_OUT))
                r_gpio_out <= write_data[GPIO_WIDTH-1:0];
            // Expiry outranks a simultaneous write-1-to-clear.
            if (w_expire)
                r_status <= 1'b1;
            else if (w_wr && (w_idx == REG_STATUS) && write_data[0])
                r_status <= 1'b0;
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign gpio_out   = r_gpio_out;
    assign timer_irq  = r_status && r_ctrl[CTRL_IRQ];

endmodule
`default_nettype wire

// File: tb/tb_gpio_timer_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_timer_peripheral
// Description : Scoreboard bench for the GPIO/timer peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_timer_peripheral;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [63:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        read_valid;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        timer_irq;

    int n_checks = 0;
    int n_pass   = 0;

    string       tag_q[$];
    logic [63:0] val_q[$];

    gpio_timer_peripheral #(
        .GPIO_WIDTH (16),
        .REGION_TAG (8'h05),
        .PRESCALE   (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .address    (address),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One bus cycle; selected reads queue their expected response.
    task automatic bus(input logic rd, input logic wr, input logic [63:0] addr,
                       input logic [63:0] wd, input string tag, input logic [63:0] exp);
        @(negedge clock);
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = wd;
        if (rd && addr[63:56] == 8'h05) begin
            tag_q.push_back(tag);
            val_q.push_back(exp);
        end
        @(posedge clock);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    function automatic logic [63:0] ra(input logic [2:0] idx);
        return {8'h05, 53'd0, idx};
    endfunction

    task automatic wr(input logic [2:0] idx, input logic [63:0] d);
        bus(1'b0, 1'b1, ra(idx), d, "wr", 64'd0);
    endtask

    task automatic rd(input logic [2:0] idx, input string tag, input logic [63:0] exp);
        bus(1'b1, 1'b0, ra(idx), 64'd0, tag, exp);
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 64'd0, 64'd0, "idle", 64'd0);
    endtask

    always @(negedge clock) begin
        if (reset_n && read_valid) begin
            if (tag_q.size() == 0) begin
                check("spurious_read_valid", 64'd1, 64'd0);
            end else begin
                check(tag_q.pop_front(), read_data, val_q.pop_front());
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        write_data = '0;
        gpio_in    = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_read_data",  read_data,  64'd0);
        check("rst_read_valid", {63'd0, read_valid}, 64'd0);
        check("rst_gpio_out",   {48'd0, gpio_out},   64'd0);
        check("rst_timer_irq",  {63'd0, timer_irq},  64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // GPIO copy through the synchronizer
        gpio_in = 16'hA5C3;
        idle();
        idle();
        rd(3'd4, "gpio_in_read", 64'hA5C3);
        wr(3'd3, 64'hA5C3);
        check("gpio_out_copy", {48'd0, gpio_out}, 64'hA5C3);
        gpio_in = 16'h1234;
        rd(3'd4, "gpio_in_latency", 64'hA5C3);

        // Region decode
        bus(1'b0, 1'b1, 64'h0400_0000_0000_0003, 64'hFFFF, "wr_other", 64'd0);
        check("region_gpio_out", {48'd0, gpio_out}, 64'hA5C3);
        bus(1'b1, 1'b0, 64'h0400_0000_0000_0004, 64'd0, "rd_other", 64'd0);
        wr(3'd6, 64'hDEAD);
        rd(3'd6, "idx6_read", 64'd0);

        // Simultaneous read and write of GPIO_OUT
        wr(3'd3, 64'h0001);
        bus(1'b1, 1'b1, ra(3'd3), 64'h00FF, "rw_old_value", 64'h0001);
        check("rw_gpio_out", {48'd0, gpio_out}, 64'h00FF);

        // One-shot timer
        wr(3'd1, 64'd3);
        wr(3'd2, 64'h5);
        rd(3'd0, "oneshot_cnt3", 64'd3);
        rd(3'd0, "oneshot_cnt2", 64'd2);
        check("oneshot_irq_early", {63'd0, timer_irq}, 64'd0);
        rd(3'd0, "oneshot_cnt1", 64'd1);
        check("oneshot_irq", {63'd0, timer_irq}, 64'd1);
        rd(3'd0, "oneshot_cnt0", 64'd0);
        rd(3'd2, "oneshot_ctrl", 64'h4);
        rd(3'd5, "oneshot_status", 64'd1);
        wr(3'd5, 64'd1);
        check("w1c_irq_clear", {63'd0, timer_irq}, 64'd0);

        // Auto-reload, W1C and disable-vs-tick
        wr(3'd1, 64'd2);
        wr(3'd2, 64'h3);
        idle();
        idle();
        bus(1'b1, 1'b1, ra(3'd5), 64'd1, "ar_status_first", 64'd1);
        rd(3'd5, "ar_status_cleared", 64'd0);
        wr(3'd5, 64'd1);
        rd(3'd5, "ar_status_set_wins", 64'd1);
        rd(3'd0, "ar_count_reloaded", 64'd2);
        wr(3'd2, 64'd0);
        rd(3'd0, "disable_holds_count", 64'd1);
        wr(3'd5, 64'd1);

        // Reset during a running timer with a read in flight
        wr(3'd1, 64'd1);
        wr(3'd2, 64'h5);
        wr(3'd1, 64'd50);
        check("pre_reset_irq", {63'd0, timer_irq}, 64'd1);
        @(negedge clock);
        mem_read = 1'b1;
        address  = ra(3'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_read_data",  read_data, 64'd0);
        check("midrst_read_valid", {63'd0, read_valid}, 64'd0);
        check("midrst_gpio_out",   {48'd0, gpio_out},   64'd0);
        check("midrst_timer_irq",  {63'd0, timer_irq},  64'd0);
        @(posedge clock);
        #1;
        check("midrst_no_valid", {63'd0, read_valid}, 64'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        mem_read = 1'b0;
        @(posedge clock);
        #1;
        rd(3'd1, "post_rst_load", 64'd0);
        rd(3'd2, "post_rst_ctrl", 64'd0);
        idle();
        idle();
        check("responses_drained", 64'(tag_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
